// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-expansion engine: mode encodings, state enum,
// schedule-size lookups and GF(2^8) helpers.
package aes_key_pkg;

    localparam logic [1:0] MODE_AES128  = 2'd0;
    localparam logic [1:0] MODE_AES192  = 2'd1;
    localparam logic [1:0] MODE_AES256  = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_EXPAND  = 3'd2,
        ST_SUBWAIT = 3'd3,
        ST_FINISH  = 3'd4
    } state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] mode);
        case (mode)
            MODE_AES128: nk_of = 4'd4;
            MODE_AES192: nk_of = 4'd6;
            default:     nk_of = 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_AES128: nr_of = 4'd10;
            MODE_AES192: nr_of = 4'd12;
            default:     nr_of = 4'd14;
        endcase
    endfunction

    // 4*(Nr+1)-1 is simply 4*Nr+3.
    function automatic logic [5:0] last_word_of(input logic [1:0] mode);
        last_word_of = {nr_of(mode), 2'b11};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            sh = xtime(sh);
        end
        gf_mul = acc;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        inv_mix_col = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

endpackage

// File: rtl/key_expansion_engine_sub_word.sv
// SubWord: four AES S-boxes with a registered output (one cycle of latency).
module key_expansion_engine_sub_word
    import aes_key_pkg::*;
(
    input  logic        CLK,
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // S-box as multiplicative inverse (b^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] word_d;
    logic [31:0] word_q;

    always_comb begin
        word_d = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                  sbox(word_in[15:8]),  sbox(word_in[7:0])};
    end

    always_ff @(posedge CLK) begin
        word_q <= word_d;
    end

    assign word_out = word_q;

endmodule

// File: rtl/key_expansion_engine.sv
// Sequential AES-128/192/256 key schedule with indexed round-key read port.
// Optional KEYEXP_INV_MIXCOL_EN adds RK_INV for equivalent-inverse-cipher round keys.
module key_expansion_engine
    import aes_key_pkg::*;
#(
    parameter logic RK_OUT_REG = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [1:0]   KEY_MODE,
    input  logic [0:255] KEY,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR,
    output logic         KEY_READY,
    input  logic [3:0]   RK_ADDR,
`ifdef KEYEXP_INV_MIXCOL_EN
    input  logic         RK_INV,
`endif
    output logic [0:127] RK_OUT
);

    state_e       state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   j_q, j_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         key_ready_q, key_ready_d;
    logic [127:0] rk_out_q, rk_out_d;
    logic [31:0]  store_q [0:59];

    logic [3:0]   nk, nr;
    logic [31:0]  prev_word, back_word, sub_in, sub_out, rcon_mask, wr_data;
    logic         need_sub, j_wrap, is_last, load_en, wr_en;
    logic [5:0]   rk_base;
    logic [127:0] rk_raw;

    assign nk        = nk_of(mode_q);
    assign nr        = nr_of(mode_q);
    assign prev_word = store_q[idx_q - 6'd1];
    assign back_word = store_q[idx_q - {2'b00, nk}];
    // j_q tracks i mod Nk so no divider is needed for Nk = 6.
    assign need_sub  = (j_q == 3'd0) || ((nk == 4'd8) && (j_q == 3'd4));
    assign j_wrap    = ({1'b0, j_q} == (nk - 4'd1));
    assign is_last   = (idx_q == last_word_of(mode_q));
    assign sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    assign rcon_mask = (j_q == 3'd0) ? {rcon_q, 24'h000000} : 32'h0000_0000;

    key_expansion_engine_sub_word u_sub_word (
        .CLK      (CLK),
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        rcon_d      = rcon_q;
        idx_d       = idx_q;
        j_d         = j_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        key_ready_d = key_ready_q;
        load_en     = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (START && (KEY_MODE == MODE_ILLEGAL)) begin
                    err_d = 1'b1;
                end else if (START) begin
                    mode_d      = KEY_MODE;
                    busy_d      = 1'b1;
                    key_ready_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                rcon_d  = 8'h01;
                idx_d   = {2'b00, nk};
                j_d     = 3'd0;
                state_d = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (need_sub) begin
                    state_d = ST_SUBWAIT;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = back_word ^ prev_word;
                end
            end
            ST_SUBWAIT: begin
                wr_en   = 1'b1;
                wr_data = back_word ^ sub_out ^ rcon_mask;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // DONE and KEY_READY are flopped on the edge that writes the final word.
        if (wr_en) begin
            if (is_last) begin
                state_d     = ST_FINISH;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                key_ready_d = 1'b1;
            end else begin
                idx_d   = idx_q + 6'd1;
                j_d     = j_wrap ? 3'd0 : (j_q + 3'd1);
                state_d = ST_EXPAND;
            end
        end else begin
            wr_data = 32'h0000_0000;
        end
    end

    // Round-key read path, optionally transformed for the equivalent inverse cipher.
    always_comb begin
        rk_base = {RK_ADDR, 2'b00};
        if (key_ready_q && (RK_ADDR <= nr)) begin
            rk_raw = {store_q[rk_base], store_q[rk_base + 6'd1],
                      store_q[rk_base + 6'd2], store_q[rk_base + 6'd3]};
        end else begin
            rk_raw = 128'h0;
        end
`ifdef KEYEXP_INV_MIXCOL_EN
        if (RK_INV && (RK_ADDR != 4'd0) && (RK_ADDR < nr)) begin
            rk_out_d = {inv_mix_col(rk_raw[127:96]), inv_mix_col(rk_raw[95:64]),
                        inv_mix_col(rk_raw[63:32]),  inv_mix_col(rk_raw[31:0])};
        end else begin
            rk_out_d = rk_raw;
        end
`else
        rk_out_d = rk_raw;
`endif
    end

    // Control and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_AES128;
            rcon_q      <= 8'h01;
            idx_q       <= 6'd8;
            j_q         <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_ready_q <= 1'b0;
            rk_out_q    <= 128'h0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rcon_q      <= rcon_d;
            idx_q       <= idx_d;
            j_q         <= j_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            key_ready_q <= key_ready_d;
            rk_out_q    <= rk_out_d;
        end
    end

    // Round-key store; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (!RST && load_en) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk) begin
                    store_q[k] <= KEY[32*k +: 32];
                end
            end
        end else if (!RST && wr_en) begin
            store_q[idx_q] <= wr_data;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign KEY_READY = key_ready_q;
    assign RK_OUT    = RK_OUT_REG ? rk_out_q : rk_out_d;

endmodule

// File: tb/tb_key_expansion_engine.sv
// Self-checking bench for key_expansion_engine: FIPS-197 vectors, timing, ERR, RST abort,
// and a spec-level key-schedule model swept over every round index.
module tb_key_expansion_engine;

    logic         clk, rst, start, rk_inv;
    logic [1:0]   key_mode;
    logic [0:255] key;
    logic         busy, done, err, key_ready;
    logic [3:0]   rk_addr;
    logic [0:127] rk_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mw [0:59];
    int          m_nr = 10;
    bit          exp_ready = 1'b0;
    bit          cmp_en = 1'b0;
    logic [3:0]  addr_s;
    logic        inv_s;
    int          msbox [0:255];

`ifdef KEYEXP_INV_MIXCOL_EN
    localparam int N_INV = 2;
`else
    localparam int N_INV = 1;
`endif

    localparam logic [0:255] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_expansion_engine #(.RK_OUT_REG(1'b1)) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .KEY_MODE  (key_mode),
        .KEY       (key),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .KEY_READY (key_ready),
        .RK_ADDR   (rk_addr),
`ifdef KEYEXP_INV_MIXCOL_EN
        .RK_INV    (rk_inv),
`endif
        .RK_OUT    (rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic int rotl8(input int x, input int s);
        return ((x << s) | (x >> (8 - s))) & 255;
    endfunction

    function automatic int bmul(input int a, input int b);
        int p = 0;
        while (b != 0) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 283;
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the generator-3 walk of GF(2^8) and its inverse walk.
    task automatic build_sbox();
        int p = 1;
        int q = 1;
        int x;
        do begin
            p = (p ^ (p << 1) ^ (((p & 128) != 0) ? 27 : 0)) & 255;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = (q ^ (q << 4)) & 255;
            if ((q & 128) != 0) q = q ^ 9;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            msbox[p] = x ^ 99;
        end while (p != 1);
        msbox[0] = 99;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {8'(msbox[t[31:24]]), 8'(msbox[t[23:16]]), 8'(msbox[t[15:8]]), 8'(msbox[t[7:0]])};
    endfunction

    function automatic logic [31:0] model_imc(input logic [31:0] c);
        int a [4];
        logic [31:0] r;
        for (int k = 0; k < 4; k++) a[k] = int'(c[31 - 8*k -: 8]);
        for (int k = 0; k < 4; k++)
            r[31 - 8*k -: 8] = 8'(bmul(a[k], 14) ^ bmul(a[(k+1)%4], 11) ^
                                  bmul(a[(k+2)%4], 13) ^ bmul(a[(k+3)%4], 9));
        return r;
    endfunction

    task automatic model_expand(input int mode, input logic [0:255] k);
        int nk, total, rc;
        logic [31:0] t;
        nk    = (mode == 0) ? 4 : (mode == 1) ? 6 : 8;
        m_nr  = nk + 6;
        total = 4 * (m_nr + 1);
        for (int i = 0; i < nk; i++) mw[i] = k[32*i +: 32];
        rc = 1;
        for (int i = nk; i < total; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {8'(rc), 24'h0};
                rc = bmul(rc, 2);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int a, input logic v);
        logic [127:0] r;
        if (!exp_ready || a > m_nr) return 128'h0;
        r = {mw[4*a], mw[4*a+1], mw[4*a+2], mw[4*a+3]};
`ifdef KEYEXP_INV_MIXCOL_EN
        if (v && a >= 1 && a < m_nr)
            r = {model_imc(r[127:96]), model_imc(r[95:64]), model_imc(r[63:32]), model_imc(r[31:0])};
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        addr_s <= rk_addr;
        inv_s  <= rk_inv;
    end

    // Every cycle with a settled schedule: DUT read port against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk($sformatf("rk_sweep a=%0d inv=%0d", addr_s, inv_s), rk_out, model_rk(int'(addr_s), inv_s));
            chk1("ready_stable", key_ready, exp_ready);
            chk1("idle_not_busy", busy, 1'b0);
        end
    end

    task automatic run(input logic [1:0] m, input logic [0:255] k, input int exp_l,
                       input int extra_at, input string nm);
        int n;
        bit busy_ok, saw_done;
        @(posedge clk); #1;
        cmp_en = 1'b0; exp_ready = 1'b0; key_mode = m; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; busy_ok = 1'b1; saw_done = 1'b0;
        while (n < 200 && !saw_done) begin
            @(negedge clk);
            if (done) begin
                saw_done = 1'b1;
            end else begin
                if (!busy || key_ready) busy_ok = 1'b0;
                @(posedge clk);
                n++;
                #1;
                start    = (n == extra_at);
                key_mode = (n == extra_at) ? 2'd2 : m;
            end
        end
        chk1({nm, "_done_seen"}, saw_done, 1'b1);
        chk({nm, "_latency"}, 128'(n), 128'(exp_l));
        chk1({nm, "_busy_during"}, busy_ok, 1'b1);
        chk1({nm, "_busy_at_done"}, busy, 1'b0);
        chk1({nm, "_ready_at_done"}, key_ready, 1'b1);
        @(negedge clk);
        chk1({nm, "_done_pulse"}, done, 1'b0);
        model_expand(int'(m), k);
        exp_ready = 1'b1;
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            for (int v = 0; v < N_INV; v++) begin
                @(posedge clk); #1;
                rk_addr = 4'(a);
                rk_inv  = v[0];
                cmp_en  = 1'b1;
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic lit(input int a, input logic v, input logic [127:0] exp, input string nm);
        @(posedge clk); #1;
        rk_addr = 4'(a);
        rk_inv  = v;
        @(posedge clk);
        @(negedge clk);
        chk(nm, rk_out, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_mode = 2'd0; key = '0; rk_addr = 4'd0; rk_inv = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_ready", key_ready, 1'b0);
        chk("rst_rk_out", rk_out, 128'h0);

        chk("model_sbox00", 128'(msbox[0]), 128'h63);
        chk("model_sbox53", 128'(msbox[83]), 128'hed);
        chk("model_imc", {96'h0, model_imc(32'h8e4da1bc)}, 128'hdb135345);

        run(2'd0, KEY128, 51, -1, "aes128");
        chk("model_128_rk1", model_rk(1, 1'b0), RK128_1);
        chk("model_128_rk10", model_rk(10, 1'b0), RK128_10);
        lit(1, 1'b0, RK128_1, "dut_128_rk1");
        lit(10, 1'b0, RK128_10, "dut_128_rk10");
        lit(11, 1'b0, 128'h0, "dut_128_rk11_oob");
        sweep();

        // Illegal mode: ERR pulse only, existing schedule untouched.
        @(posedge clk); #1;
        cmp_en = 1'b0; key_mode = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; key_mode = 2'd0;
        @(negedge clk);
        chk1("err_pulse", err, 1'b1);
        chk1("err_busy", busy, 1'b0);
        chk1("err_ready_kept", key_ready, 1'b1);
        @(negedge clk);
        chk1("err_pulse_end", err, 1'b0);
        sweep();

        run(2'd1, KEY192, 55, -1, "aes192");
        chk("model_192_rk12", model_rk(12, 1'b0), RK192_12);
        lit(12, 1'b0, RK192_12, "dut_192_rk12");
        sweep();

        run(2'd2, KEY256, 66, -1, "aes256");
        chk("model_256_rk14", model_rk(14, 1'b0), RK256_14);
        lit(14, 1'b0, RK256_14, "dut_256_rk14");
        sweep();

        run(2'd0, KEY128, 51, 10, "aes128_restart_ignored");
        sweep();

        // Reset in the middle of an AES-256 expansion.
        @(posedge clk); #1;
        cmp_en = 1'b0; exp_ready = 1'b0; key_mode = 2'd2; key = KEY256; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", key_ready, 1'b0);
        chk("abort_rk_out", rk_out, 128'h0);
        chk1("abort_done", done, 1'b0);
        sweep();

        run(2'd0, KEY128, 51, -1, "aes128_after_rst");
        lit(1, 1'b0, RK128_1, "dut_128b_rk1");
        lit(10, 1'b0, RK128_10, "dut_128b_rk10");
`ifdef KEYEXP_INV_MIXCOL_EN
        lit(0, 1'b1, RK128_0, "inv_round0_raw");
        lit(10, 1'b1, RK128_10, "inv_round10_raw");
`else
        lit(0, 1'b0, RK128_0, "dut_128b_rk0");
`endif
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
